cp0_exception_unit: RTL and testbench
=====================================

# cp0_exception_unit

Coprocessor-0 exception and interrupt controller in the memory stage of the five-stage pipeline. It consumes the exception codes raised upstream, including the arithmetic overflow (Ov) and address-overflow (AdEL/AdES) conditions produced by the execute-stage ALU, plus the six hardware interrupt lines. It decides whether to take an exception, latches the victim PC, the cause and the branch-delay flag, and serves `mfc0`/`mtc0`/`eret`. Its `Req` output flushes the pipeline and redirects fetch to the handler.

## Interface
- `PRID_VALUE`, default 32'h0000_3300: value returned for PRId reads (see Configuration).
- `clk`  in  1  clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  `mtc0` write enable (M stage).
- `CP0Add`  in  5  register address for read/write (12 SR, 13 Cause, 14 EPC, 15 PRId).
- `CP0In`  in  32  `mtc0` write data.
- `CP0Out`  out  32  `mfc0` read data, combinational.
- `VPC`  in  32  PC of the M-stage (victim) instruction.
- `BDIn`  in  1  victim is in a branch delay slot.
- `ExcCodeIn`  in  5  pending exception code, 0 = none (4 AdEL, 5 AdES, 8 Syscall, 10 RI, 12 Ov).
- `HWInt`  in  6  hardware interrupt lines, level sensitive.
- `EXLClr`  in  1  `eret` in M stage.
- `EPCOut`  out  32  current EPC register, for `eret` redirect.
- `Req`  out  1  take exception/interrupt this cycle, combinational.

## Operation
- SR (12): IM = bits[15:10], EXL = bit 1, IE = bit 0; other bits read 0.
- Cause (13): BD = bit 31, IP = bits[15:10], ExcCode = bits[6:2]; other bits read 0. Cause is read-only to `mtc0` (writes ignored).
- EPC (14): 32 bits, bits[1:0] always 0.
- IntReq = |(HWInt & IM) & IE & ~EXL. ExcReq = (ExcCodeIn != 0) & ~EXL. Req = IntReq | ExcReq.
- Priority: an interrupt beats a synchronous exception in the same cycle, so ExcCode is latched as 0.
- On Req, at the clock edge:
  - EXL <= 1.
  - ExcCode <= IntReq ? 0 : ExcCodeIn.
  - BD <= BDIn.
  - EPC <= (BDIn ? VPC - 4 : VPC) & ~3. The subtraction is 32-bit modular, so VPC = 0 with BDIn gives 32'hFFFF_FFFC.
- IP <= HWInt every cycle, independent of Req.
- `mtc0` (en = 1, Req = 0):
  - SR writes IM, EXL and IE from the corresponding CP0In bits.
  - EPC writes CP0In & ~3.
- `eret` (EXLClr = 1): EXL <= 0. No effect when EXL is already 0.
- Simultaneous events:
  - Req with en: Req wins and the `mtc0` write is dropped.
  - Req cannot coincide with a meaningful EXLClr, because Req requires EXL = 0.
  - en writing SR with EXLClr: the EXL bit ends at 0, and the IM/IE bits take CP0In.
- Any other read address returns 0.

## Timing
- Reset (async, reset_n low):
  - SR = 0, Cause = 0, EPC = 0.
  - Req = 0, CP0Out = 0 for all addresses except PRId.
  - EPCOut = 0.
  - Reset mid-exception clears EXL immediately, without a clock edge.
- Req is combinational, with zero latency from HWInt, ExcCodeIn and SR.
- Register effects of Req are visible from the next cycle.
- CP0Out is combinational from the register state and does not forward a same-cycle `mtc0`.
- EPCOut reflects an `mtc0` EPC write or an exception capture one cycle later.
- While EXL = 1, further exceptions and interrupts are masked: no nesting.

## Configuration
- `CP0_PRID_EN` defined: address 15 reads PRID_VALUE, and writes to it are ignored.
- `CP0_PRID_EN` undefined: no PRId logic is built, and address 15 reads 0.

## Test plan
- Reset, then read 12/13/14 -> all 0. Set SR = 32'h0000_FC01 via `mtc0` -> SR reads 32'h0000_FC01.
- ExcCodeIn = 12, VPC = 32'h0000_3010, BDIn = 0 -> Req = 1 that cycle. Next cycle: Cause[6:2] = 12, EPC = 32'h0000_3010, EXL = 1, Req = 0 with ExcCodeIn still 12.
- ExcCodeIn = 4, VPC = 32'h0000_3008, BDIn = 1 -> EPC = 32'h0000_3004, Cause = 32'h8000_0010.
- IM = 6'b000100, IE = 1, HWInt = 6'b000100 together with ExcCodeIn = 10 -> Req = 1, ExcCode latched 0, IP = 6'b000100.
- With EXL = 1, assert EXLClr -> EXL = 0 next cycle. In the same cycle as a Req, `mtc0` EPC = 32'h1234 is dropped.
- Reset_n pulsed low mid-cycle while EXL = 1 -> EXL = 0 immediately. Reading address 15 gives PRID_VALUE with `CP0_PRID_EN` defined, 0 without.

Source files
------------

// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 exception/interrupt controller: SR, Cause and EPC, plus the Req flush request.
// Optional PRId register at address 15 is built only when CP0_PRID_EN is defined.
module cp0_exception_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_3300
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  // A delay-slot victim restarts at its branch; wraps modulo 2^32.
  function automatic logic [31:0] victim_epc(input logic [31:0] pc, input logic bd);
    logic [31:0] base;
    base = bd ? (pc - 32'd4) : pc;
    return base & ~32'd3;
  endfunction

  assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
  assign req     = int_req | exc_req;
  assign Req     = req;
  assign EPCOut  = epc_q;

  assign sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
  assign cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = HWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;

    // mtc0 is applied first so eret and exception entry can override it.
    if (en && !req) begin
      if (CP0Add == ADDR_SR) begin
        im_d  = CP0In[15:10];
        exl_d = CP0In[1];
        ie_d  = CP0In[0];
      end else if (CP0Add == ADDR_EPC) begin
        epc_d = CP0In & ~32'd3;
      end
    end

    if (EXLClr) begin
      exl_d = 1'b0;
    end

    if (req) begin
      exl_d      = 1'b1;
      exc_code_d = int_req ? 5'd0 : ExcCodeIn;
      bd_d       = BDIn;
      epc_d      = victim_epc(VPC, BDIn);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

`ifdef CP0_PRID_EN
  always_comb begin
    CP0Out = 32'd0;
    case (CP0Add)
      ADDR_SR:    CP0Out = sr_val;
      ADDR_CAUSE: CP0Out = cause_val;
      ADDR_EPC:   CP0Out = epc_q;
      ADDR_PRID:  CP0Out = PRID_VALUE;
      default:    CP0Out = 32'd0;
    endcase
  end
`else
  logic unused_prid;
  assign unused_prid = ^{PRID_VALUE, ADDR_PRID};

  always_comb begin
    CP0Out = 32'd0;
    case (CP0Add)
      ADDR_SR:    CP0Out = sr_val;
      ADDR_CAUSE: CP0Out = cause_val;
      ADDR_EPC:   CP0Out = epc_q;
      default:    CP0Out = 32'd0;
    endcase
  end
`endif

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Scoreboard bench for cp0_exception_unit: expectations queued at stimulus, popped at observation.
module tb_cp0_exception_unit;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;

  int          total;
  int          bad;
  logic [31:0] exp_q[$];
  logic [31:0] obs;
  logic [31:0] exp;
  logic [31:0] prid_exp;

  cp0_exception_unit dut (
    .clk(clk), .reset_n(reset_n), .en(en), .CP0Add(CP0Add), .CP0In(CP0In),
    .CP0Out(CP0Out), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .EPCOut(EPCOut), .Req(Req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    CP0Add = a;
    #1;
    d = CP0Out;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; CP0Add = a; CP0In = d;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic eret();
    @(negedge clk);
    EXLClr = 1'b1;
    @(negedge clk);
    EXLClr = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(prid_exp); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    rd(5'd12, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL reset_sr got=%h want=%h", obs, exp); end
    rd(5'd13, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL reset_cause got=%h want=%h", obs, exp); end
    rd(5'd14, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL reset_epc got=%h want=%h", obs, exp); end
    rd(5'd15, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL reset_prid got=%h want=%h", obs, exp); end
    exp = exp_q.pop_front(); total++;
    if ({31'd0, Req} !== exp) begin bad++; $display("FAIL reset_req got=%b want=%h", Req, exp); end
    exp = exp_q.pop_front(); total++;
    if (EPCOut !== exp) begin bad++; $display("FAIL reset_epcout got=%h want=%h", EPCOut, exp); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_mtc0();
    wr(5'd12, 32'hFFFF_FC01);
    exp_q.push_back(32'h0000_FC01);
    rd(5'd12, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL sr_write got=%h want=%h", obs, exp); end
    wr(5'd13, 32'hFFFF_FFFF);
    exp_q.push_back(32'd0);
    rd(5'd13, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL cause_readonly got=%h want=%h", obs, exp); end
    // EPC write: same-cycle read must still show the old value
    @(negedge clk);
    en = 1'b1; CP0In = 32'h0000_1237;
    exp_q.push_back(32'd0);
    rd(5'd14, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL epc_no_forward got=%h want=%h", obs, exp); end
    @(negedge clk);
    en = 1'b0;
    exp_q.push_back(32'h0000_1234); exp_q.push_back(32'h0000_1234);
    rd(5'd14, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL epc_write got=%h want=%h", obs, exp); end
    exp = exp_q.pop_front(); total++;
    if (EPCOut !== exp) begin bad++; $display("FAIL epcout_write got=%h want=%h", EPCOut, exp); end
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    rd(5'd20, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL bad_addr got=%h want=%h", obs, exp); end
    exp = exp_q.pop_front(); total++;
    if ({31'd0, Req} !== exp) begin bad++; $display("FAIL idle_req got=%b want=%h", Req, exp); end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    ExcCodeIn = 5'd12; VPC = 32'h0000_3010; BDIn = 1'b0;
    exp_q.push_back(32'd1);
    #1; exp = exp_q.pop_front(); total++;
    if ({31'd0, Req} !== exp) begin bad++; $display("FAIL ov_req got=%b want=%h", Req, exp); end
    @(negedge clk);
    exp_q.push_back(32'd0); exp_q.push_back(32'h0000_0030);
    exp_q.push_back(32'h0000_3010); exp_q.push_back(32'h0000_FC03);
    #1; exp = exp_q.pop_front(); total++;
    if ({31'd0, Req} !== exp) begin bad++; $display("FAIL ov_req_masked got=%b want=%h", Req, exp); end
    rd(5'd13, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL ov_cause got=%h want=%h", obs, exp); end
    rd(5'd14, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL ov_epc got=%h want=%h", obs, exp); end
    rd(5'd12, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL ov_sr_exl got=%h want=%h", obs, exp); end
    ExcCodeIn = 5'd0;
    eret();
    exp_q.push_back(32'h0000_FC01);
    rd(5'd12, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL eret_sr got=%h want=%h", obs, exp); end
  endtask

  task automatic test_delay_slot();
    @(negedge clk);
    ExcCodeIn = 5'd4; VPC = 32'h0000_3008; BDIn = 1'b1;
    @(negedge clk);
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    exp_q.push_back(32'h0000_3004); exp_q.push_back(32'h8000_0010);
    rd(5'd14, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL bd_epc got=%h want=%h", obs, exp); end
    rd(5'd13, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL bd_cause got=%h want=%h", obs, exp); end
    eret();
  endtask

  task automatic test_interrupt();
    wr(5'd12, 32'h0000_1001);
    @(negedge clk);
    HWInt = 6'b000010;
    exp_q.push_back(32'd0);
    #1; exp = exp_q.pop_front(); total++;
    if ({31'd0, Req} !== exp) begin bad++; $display("FAIL int_masked got=%b want=%h", Req, exp); end
    @(negedge clk);
    HWInt = 6'b000100; ExcCodeIn = 5'd10; VPC = 32'h0000_5000;
    exp_q.push_back(32'd1);
    #1; exp = exp_q.pop_front(); total++;
    if ({31'd0, Req} !== exp) begin bad++; $display("FAIL int_req got=%b want=%h", Req, exp); end
    @(negedge clk);
    ExcCodeIn = 5'd0;
    exp_q.push_back(32'h0000_1000); exp_q.push_back(32'h0000_1003);
    rd(5'd13, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL int_cause got=%h want=%h", obs, exp); end
    rd(5'd12, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL int_sr got=%h want=%h", obs, exp); end
    HWInt = 6'd0;
    eret();
    exp_q.push_back(32'd0);
    rd(5'd13, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL ip_follows got=%h want=%h", obs, exp); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    ExcCodeIn = 5'd8; VPC = 32'h0000_4000; BDIn = 1'b0;
    en = 1'b1; CP0Add = 5'd14; CP0In = 32'h0000_1234;
    @(negedge clk);
    en = 1'b0; ExcCodeIn = 5'd0;
    exp_q.push_back(32'h0000_4000);
    #1; exp = exp_q.pop_front(); total++;
    if (EPCOut !== exp) begin bad++; $display("FAIL req_drops_mtc0 got=%h want=%h", EPCOut, exp); end
    @(negedge clk);
    en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0403; EXLClr = 1'b1;
    @(negedge clk);
    en = 1'b0; EXLClr = 1'b0;
    exp_q.push_back(32'h0000_0401);
    rd(5'd12, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL eret_with_mtc0 got=%h want=%h", obs, exp); end
  endtask

  task automatic test_epc_edges();
    @(negedge clk);
    ExcCodeIn = 5'd5; VPC = 32'd0; BDIn = 1'b1;
    @(negedge clk);
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h8000_0014);
    rd(5'd14, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL epc_wrap got=%h want=%h", obs, exp); end
    rd(5'd13, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL wrap_cause got=%h want=%h", obs, exp); end
    eret();
    @(negedge clk);
    ExcCodeIn = 5'd12; VPC = 32'h0000_3013;
    @(negedge clk);
    exp_q.push_back(32'h0000_3010);
    #1; exp = exp_q.pop_front(); total++;
    if (EPCOut !== exp) begin bad++; $display("FAIL epc_align got=%h want=%h", EPCOut, exp); end
    // EXL still set: a new exception must neither request nor capture
    ExcCodeIn = 5'd4; VPC = 32'h0000_9000;
    exp_q.push_back(32'd0);
    #1; exp = exp_q.pop_front(); total++;
    if ({31'd0, Req} !== exp) begin bad++; $display("FAIL nest_req got=%b want=%h", Req, exp); end
    @(negedge clk);
    ExcCodeIn = 5'd0;
    exp_q.push_back(32'h0000_3010);
    #1; exp = exp_q.pop_front(); total++;
    if (EPCOut !== exp) begin bad++; $display("FAIL nest_epc got=%h want=%h", EPCOut, exp); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(prid_exp);
    rd(5'd12, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL async_sr got=%h want=%h", obs, exp); end
    exp = exp_q.pop_front(); total++;
    if (EPCOut !== exp) begin bad++; $display("FAIL async_epcout got=%h want=%h", EPCOut, exp); end
    rd(5'd15, obs); exp = exp_q.pop_front(); total++;
    if (obs !== exp) begin bad++; $display("FAIL prid_read got=%h want=%h", obs, exp); end
    @(negedge clk);
    reset_n = 1'b1;
    ExcCodeIn = 5'd12; VPC = 32'h0000_7000;
    exp_q.push_back(32'd1);
    #1; exp = exp_q.pop_front(); total++;
    if ({31'd0, Req} !== exp) begin bad++; $display("FAIL post_reset_req got=%b want=%h", Req, exp); end
    @(negedge clk);
    ExcCodeIn = 5'd0;
  endtask

  initial begin
    total = 0; bad = 0;
`ifdef CP0_PRID_EN
    prid_exp = 32'h0000_3300;
`else
    prid_exp = 32'd0;
`endif
    reset_n = 1'b0; en = 1'b0; CP0Add = 5'd0; CP0In = 32'd0; VPC = 32'd0;
    BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_mtc0();
    test_overflow();
    test_delay_slot();
    test_interrupt();
    test_simultaneous();
    test_epc_edges();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
